// File: rtl/matrix_dac_sched.sv
// Round-robin scheduler sharing one matrix_dac engine among NREQ requesters.
// Latches job parameters at grant and watches engine STATE for start, completion and timeout.
module matrix_dac_sched #(
  parameter int NREQ       = 4,
  parameter int ROW_W      = 5,
  parameter int COL_W      = 13,
  parameter int TIMEOUT    = 65536,
  parameter int START_WAIT = 4,
  localparam int ID_W      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ROW_W-1:0] req_row,
  input  logic [NREQ*COL_W-1:0] req_col,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       err,
  output logic                  eng_trg,
  output logic [ROW_W-1:0]      eng_row1,
  output logic [COL_W-1:0]      eng_column,
  input  logic [3:0]            eng_state,
  output logic                  busy,
  output logic [ID_W-1:0]       cur_id
);

  typedef enum logic [1:0] {IDLE, WAIT_START, RUN, FIN} state_e;

  localparam int unsigned NREQ_U = NREQ;
  localparam logic [19:0] SW_MAX = 20'(START_WAIT);
  localparam logic [19:0] TO_MAX = 20'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [19:0]      wait_q, wait_d, wdog_q, wdog_d;
  logic [19:0]      wait_inc, wdog_inc;
  logic [ID_W-1:0]  ptr_q, ptr_d, id_q, id_d;
  logic [NREQ-1:0]  ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic             trg_q, trg_d, busy_q, busy_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ID_W-1:0]  win;
  logic             found;
  logic             eng_idle;

  assign eng_idle = (eng_state == 4'd0);
  assign wait_inc = (wait_q == '1) ? wait_q : wait_q + 20'd1;
  assign wdog_inc = (wdog_q == '1) ? wdog_q : wdog_q + 20'd1;

  // First set request at or above ptr, wrapping modulo NREQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (!found && req[(32'(ptr_q) + i) % NREQ_U]) begin
        found = 1'b1;
        win   = ID_W'((32'(ptr_q) + i) % NREQ_U);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    wdog_d  = wdog_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = '0;
    trg_d   = 1'b0;
    busy_d  = busy_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (found && eng_idle) begin
          ack_d[win] = 1'b1;
          trg_d      = 1'b1;
          row_d      = req_row[win*ROW_W +: ROW_W];
          col_d      = req_col[win*COL_W +: COL_W];
          id_d       = win;
          busy_d     = 1'b1;
          wait_d     = '0;
          state_d    = WAIT_START;
        end
      end
      WAIT_START: begin
        if (!eng_idle) begin
          wdog_d  = '0;
          state_d = RUN;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == SW_MAX) begin
            err_d[id_q] = 1'b1;
            state_d     = FIN;
          end
        end
      end
      RUN: begin
        if (eng_idle) begin
          done_d[id_q] = 1'b1;
          state_d      = FIN;
        end else begin
          wdog_d = wdog_inc;
          if (wdog_q == TO_MAX) begin
            err_d[id_q] = 1'b1;
            state_d     = FIN;
          end
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        ptr_d   = (int'(id_q) == NREQ - 1) ? '0 : id_q + ID_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      wdog_q  <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      trg_q   <= 1'b0;
      busy_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      wdog_q  <= wdog_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      trg_q   <= trg_d;
      busy_q  <= busy_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign ack        = ack_q;
  assign done       = done_q;
  assign err        = err_q;
  assign eng_trg    = trg_q;
  assign eng_row1   = row_q;
  assign eng_column = col_q;
  assign busy       = busy_q;
  assign cur_id     = id_q;

endmodule
